// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD host agent: command codes, FSM state encoding and
// image geometry.
package lcd_pkg;

  localparam int IMG_AW = 6;
  localparam int PIX_W  = 8;

  typedef logic [2:0] cmd_code_t;

  localparam cmd_code_t CMD_WRITE = 3'd0;
  localparam cmd_code_t CMD_UP    = 3'd1;
  localparam cmd_code_t CMD_DOWN  = 3'd2;
  localparam cmd_code_t CMD_LEFT  = 3'd3;
  localparam cmd_code_t CMD_RIGHT = 3'd4;
  localparam cmd_code_t CMD_AVG   = 3'd5;
  localparam cmd_code_t CMD_MIRX  = 3'd6;
  localparam cmd_code_t CMD_MIRY  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_WAIT,
    ST_ISSUE,
    ST_ACK,
    ST_EXEC,
    ST_FINISH,
    ST_ERR
  } state_e;

endpackage

// File: rtl/lcd_img_ram.sv
// 64x8 pixel RAM: one synchronous write port and one read port that is either registered
// (read-before-write on a same-address collision) or combinational, chosen by REG_RD.
module lcd_img_ram
  import lcd_pkg::*;
#(
  parameter bit REG_RD = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IMG_AW-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [IMG_AW-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  localparam int DEPTH = 1 << IMG_AW;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rd_q;

  // NOTE: the storage array has no reset so it maps onto plain RAM; its contents are
  // preloaded by the host and deliberately survive a reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; this is also what gives the read port its old-data behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
  end

  assign rd_data = REG_RD ? rd_q : mem[rd_addr];

endmodule

// File: rtl/lcd_host_agent.sv
// Host-side agent for the LCD controller: serves IROM reads, sequences a preloaded command
// list over the cmd/cmd_valid/busy handshake, captures IRB writes and flags finish/timeout.
module lcd_host_agent
  import lcd_pkg::*;
#(
  parameter int CMD_DEPTH = 32,
  parameter int CMD_AW    = 5,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              img_wr_en,
  input  logic [IMG_AW-1:0] img_wr_addr,
  input  logic [PIX_W-1:0]  img_wr_data,
  input  logic              cmd_wr_en,
  input  logic [CMD_AW-1:0] cmd_wr_addr,
  input  logic [2:0]        cmd_wr_data,
  input  logic [CMD_AW:0]   cmd_count,
  input  logic              IROM_EN,
  input  logic [IMG_AW-1:0] IROM_A,
  output logic [PIX_W-1:0]  IROM_Q,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  input  logic              IRB_RW,
  input  logic [IMG_AW-1:0] IRB_A,
  input  logic [PIX_W-1:0]  IRB_D,
  input  logic [IMG_AW-1:0] res_rd_addr,
  output logic [PIX_W-1:0]  res_rd_data,
  output logic              finish,
  output logic              timeout,
  output logic [CMD_AW:0]   cmds_issued
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [CMD_AW:0]   ptr_q, ptr_d, ptr_inc, count_q, cmds_issued_q;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              wd_expired, waiting, idle;
  cmd_code_t         cmd_q;
  logic              cmd_valid_q, finish_q, timeout_q;
  cmd_code_t         cmd_mem [CMD_DEPTH];

  assign idle       = (state_q == ST_IDLE);
  assign ptr_inc    = ptr_q + (CMD_AW + 1)'(1);
  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
  assign waiting    = (state_q == ST_LOAD_WAIT) || (state_q == ST_ACK) || (state_q == ST_EXEC);

  always_ff @(posedge clk) begin
    if (idle && cmd_wr_en) begin
      cmd_mem[cmd_wr_addr] <= cmd_wr_data;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_WAIT;
          ptr_d   = '0;
        end
      end
      ST_LOAD_WAIT: begin
        if (!busy)           state_d = (ptr_q < count_q) ? ST_ISSUE : ST_FINISH;
        else if (wd_expired) state_d = ST_ERR;
      end
      ST_ISSUE: state_d = ST_ACK;
      ST_ACK: begin
        if (busy)            state_d = ST_EXEC;
        else if (wd_expired) state_d = ST_ERR;
      end
      ST_EXEC: begin
        // A WRITE ends the session on done; later list entries are never issued.
        if (cmd_q == CMD_WRITE) begin
          if (done)            state_d = ST_FINISH;
          else if (wd_expired) state_d = ST_ERR;
        end else if (!busy) begin
          ptr_d   = ptr_inc;
          state_d = (ptr_inc < count_q) ? ST_ISSUE : ST_FINISH;
        end else if (wd_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    wd_d = (waiting && (state_d == state_q)) ? wd_q + WD_W'(1) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      count_q       <= '0;
      wd_q          <= '0;
      cmd_q         <= CMD_WRITE;
      cmd_valid_q   <= 1'b0;
      finish_q      <= 1'b0;
      timeout_q     <= 1'b0;
      cmds_issued_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wd_q        <= wd_d;
      // cmd and cmd_valid are loaded on entry to ISSUE so both are valid in that cycle.
      cmd_valid_q <= (state_d == ST_ISSUE);
      if (state_d == ST_ISSUE) begin
        cmd_q         <= cmd_mem[ptr_d[CMD_AW-1:0]];
        cmds_issued_q <= cmds_issued_q + (CMD_AW + 1)'(1);
      end
      if (idle && start) begin
        count_q       <= cmd_count;
        finish_q      <= 1'b0;
        timeout_q     <= 1'b0;
        cmds_issued_q <= '0;
      end
      if (state_q == ST_FINISH) finish_q  <= 1'b1;
      if (state_q == ST_ERR)    timeout_q <= 1'b1;
    end
  end

  lcd_img_ram #(.REG_RD(1'b1)) u_img_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (idle && img_wr_en),
    .wr_addr (img_wr_addr),
    .wr_data (img_wr_data),
    .rd_en   (!IROM_EN),
    .rd_addr (IROM_A),
    .rd_data (IROM_Q)
  );

  lcd_img_ram #(.REG_RD(1'b0)) u_res_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (!idle && !IRB_RW),
    .wr_addr (IRB_A),
    .wr_data (IRB_D),
    .rd_en   (1'b0),
    .rd_addr (res_rd_addr),
    .rd_data (res_rd_data)
  );

  assign cmd         = cmd_q;
  assign cmd_valid   = cmd_valid_q;
  assign finish      = finish_q;
  assign timeout     = timeout_q;
  assign cmds_issued = cmds_issued_q;

endmodule

// File: tb/tb_lcd_host_agent.sv
// Self-checking bench for lcd_host_agent: vector tables for IROM and result reads, plus
// directed sequences against a small controller model for the handshake corner cases.
module tb_lcd_host_agent;
  import lcd_pkg::*;

  localparam int CMD_AW = 5;

  typedef struct {
    logic       en_n;
    logic [5:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start, img_wr_en, cmd_wr_en, IROM_EN, busy, done, IRB_RW;
  logic [5:0]      img_wr_addr, IROM_A, IRB_A, res_rd_addr;
  logic [7:0]      img_wr_data, IRB_D, IROM_Q, res_rd_data;
  logic [4:0]      cmd_wr_addr;
  logic [2:0]      cmd_wr_data, cmd;
  logic [CMD_AW:0] cmd_count, cmds_issued;
  logic            cmd_valid, finish, timeout;

  lcd_host_agent #(.CMD_DEPTH(32), .CMD_AW(CMD_AW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr), .img_wr_data(img_wr_data),
    .cmd_wr_en(cmd_wr_en), .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
    .cmd_count(cmd_count), .IROM_EN(IROM_EN), .IROM_A(IROM_A), .IROM_Q(IROM_Q),
    .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
    .IRB_RW(IRB_RW), .IRB_A(IRB_A), .IRB_D(IRB_D),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .finish(finish), .timeout(timeout), .cmds_issued(cmds_issued)
  );

  // Controller model: answers each cmd_valid with a busy window; a WRITE also pulses done.
  logic      model_en = 1'b0;
  logic      man_busy = 1'b0;
  logic      mdl_busy = 1'b0;
  logic      mdl_done = 1'b0;
  int        hold_cyc = 3;
  int        cyc      = 0;
  int        n_pulses = 0;
  int        done_cyc = 0;
  logic [2:0] seen_cmd [$];
  int        issue_cyc [$];
  int        fall_cyc [$];

  assign busy = model_en ? mdl_busy : man_busy;
  assign done = model_en ? mdl_done : 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cmd_valid) n_pulses <= n_pulses + 1;

  always begin
    @(posedge clk); #1;
    if (model_en && cmd_valid) begin
      seen_cmd.push_back(cmd);
      issue_cyc.push_back(cyc);
      mdl_busy = 1'b1;
      repeat (hold_cyc) begin @(posedge clk); #1; end
      if (cmd == CMD_WRITE) begin
        mdl_done = 1'b1;
        done_cyc = cyc;
        @(posedge clk); #1;
        mdl_done = 1'b0;
      end
      mdl_busy = 1'b0;
      fall_cyc.push_back(cyc);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_img(input logic [5:0] a, input logic [7:0] d);
    img_wr_en = 1'b1; img_wr_addr = a; img_wr_data = d;
    tick();
    img_wr_en = 1'b0;
  endtask

  task automatic wr_cmd(input logic [4:0] a, input logic [2:0] c);
    cmd_wr_en = 1'b1; cmd_wr_addr = a; cmd_wr_data = c;
    tick();
    cmd_wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [CMD_AW:0] n);
    cmd_count = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_finish(input int max_cyc, input string name, output int fin_cyc);
    int k = 0;
    while (!finish && k < max_cyc) begin tick(); k++; end
    fin_cyc = cyc;
    check(name, finish, 1);
  endtask

  rd_vec_t    irom_vecs [7];
  rd_vec_t    res_vecs  [5];
  logic [2:0] exp_cap   [8];
  logic [2:0] exp_list  [3];

  initial begin
    int base, p0, fin_cyc;

    irom_vecs = '{'{1'b0, 6'd5, 8'd5},  '{1'b0, 6'd63, 8'd63}, '{1'b1, 6'd10, 8'd63},
                  '{1'b1, 6'd0, 8'd63}, '{1'b0, 6'd0, 8'd0},   '{1'b0, 6'd42, 8'd42},
                  '{1'b1, 6'd17, 8'd42}};
    res_vecs  = '{'{1'b0, 6'd5, 8'd58}, '{1'b0, 6'd0, 8'd63}, '{1'b0, 6'd63, 8'd0},
                  '{1'b0, 6'd32, 8'd31}, '{1'b0, 6'd20, 8'd43}};
    exp_cap   = '{CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_AVG, CMD_MIRX, CMD_MIRY, CMD_UP};
    exp_list  = '{CMD_RIGHT, CMD_AVG, CMD_WRITE};

    reset = 1'b1; start = 1'b0; img_wr_en = 1'b0; cmd_wr_en = 1'b0; IROM_EN = 1'b1;
    IRB_RW = 1'b1; img_wr_addr = '0; img_wr_data = '0; cmd_wr_addr = '0; cmd_wr_data = '0;
    cmd_count = '0; IROM_A = '0; IRB_A = '0; IRB_D = '0; res_rd_addr = '0;

    // Reset state
    repeat (3) tick();
    check("rst_irom_q", IROM_Q, 0);
    check("rst_cmd", cmd, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_finish", finish, 0);
    check("rst_timeout", timeout, 0);
    check("rst_cmds_issued", cmds_issued, 0);
    reset = 1'b0;
    tick();

    // Image ramp, then a same-address write/read collision returns the old pixel
    for (int i = 0; i < 64; i++) wr_img(6'(i), 8'(i));
    IROM_EN = 1'b0; IROM_A = 6'd7;
    img_wr_en = 1'b1; img_wr_addr = 6'd7; img_wr_data = 8'hAA;
    tick();
    img_wr_en = 1'b0;
    check("rbw_old_data", IROM_Q, 7);
    tick();
    check("rbw_new_data", IROM_Q, 8'hAA);
    IROM_EN = 1'b1;
    wr_img(6'd7, 8'd7);

    for (int i = 0; i < 7; i++) begin
      IROM_EN = irom_vecs[i].en_n; IROM_A = irom_vecs[i].addr;
      tick();
      check($sformatf("irom_vec%0d", i), IROM_Q, irom_vecs[i].exp);
    end
    for (int a = 0; a < 64; a++) begin
      IROM_EN = 1'b0; IROM_A = 6'(a);
      tick();
      check($sformatf("irom_ramp%0d", a), IROM_Q, a);
    end
    IROM_EN = 1'b1;

    // Empty list: finish three edges after start, no command strobe
    p0 = n_pulses; man_busy = 1'b0;
    do_start('0);
    check("cnt0_fin_e0", finish, 0);
    tick();
    check("cnt0_fin_e1", finish, 0);
    tick();
    check("cnt0_fin_e2", finish, 1);
    check("cnt0_pulses", n_pulses - p0, 0);
    check("cnt0_issued", cmds_issued, 0);

    // Capture session: eight non-WRITE commands keep the agent busy while IRB writes land
    for (int i = 0; i < 8; i++) wr_cmd(5'(i), exp_cap[i]);
    model_en = 1'b1; hold_cyc = 10; base = seen_cmd.size(); p0 = n_pulses;
    do_start(6'd8);
    tick();
    IRB_RW = 1'b0; IRB_A = 6'd5; IRB_D = 8'h11;
    img_wr_en = 1'b1; img_wr_addr = 6'd3; img_wr_data = 8'hFF;
    cmd_wr_en = 1'b1; cmd_wr_addr = 5'd1; cmd_wr_data = CMD_WRITE;
    tick();
    img_wr_en = 1'b0; cmd_wr_en = 1'b0;
    for (int a = 0; a < 64; a++) begin
      IRB_A = 6'(a); IRB_D = 8'(63 - a);
      tick();
    end
    IRB_RW = 1'b1;
    wait_finish(200, "cap_finish", fin_cyc);
    check("cap_issued", cmds_issued, 8);
    check("cap_pulses", n_pulses - p0, 8);
    check("cap_seen_n", seen_cmd.size() - base, 8);
    if (seen_cmd.size() - base >= 8)
      for (int i = 0; i < 8; i++) check($sformatf("cap_cmd%0d", i), seen_cmd[base + i], exp_cap[i]);
    for (int i = 0; i < 5; i++) begin
      res_rd_addr = res_vecs[i].addr; #1;
      check($sformatf("res_vec%0d", i), res_rd_data, res_vecs[i].exp);
    end
    IRB_RW = 1'b0; IRB_A = 6'd0; IRB_D = 8'h99;
    tick();
    IRB_RW = 1'b1; res_rd_addr = 6'd0; #1;
    check("res_idle_ignored", res_rd_data, 63);
    IROM_EN = 1'b0; IROM_A = 6'd3;
    tick();
    IROM_EN = 1'b1;
    check("img_session_wr_dropped", IROM_Q, 3);

    // List {RIGHT, AVG, WRITE, UP}: stops after WRITE
    wr_cmd(5'd0, CMD_RIGHT); wr_cmd(5'd1, CMD_AVG); wr_cmd(5'd2, CMD_WRITE); wr_cmd(5'd3, CMD_UP);
    hold_cyc = 3; base = seen_cmd.size(); p0 = n_pulses;
    do_start(6'd4);
    wait_finish(100, "list_finish", fin_cyc);
    repeat (4) tick();
    check("list_pulses", n_pulses - p0, 3);
    check("list_issued", cmds_issued, 3);
    check("list_timeout", timeout, 0);
    check("list_fin_after_done", fin_cyc > done_cyc, 1);
    check("list_seen_n", seen_cmd.size() - base, 3);
    if (seen_cmd.size() - base >= 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("list_cmd%0d", i), seen_cmd[base + i], exp_list[i]);
      check("list_3rd_after_fall", issue_cyc[base + 2] > fall_cyc[base + 1], 1);
    end

    // Reset in ACK, then a clean rerun
    model_en = 1'b0; man_busy = 1'b0;
    do_start(6'd4);
    tick();
    check("rack_issue_valid", cmd_valid, 1);
    check("rack_issue_cmd", cmd, CMD_RIGHT);
    tick();
    check("rack_ack_issued", cmds_issued, 1);
    reset = 1'b1; #1;
    check("rack_cmd_valid", cmd_valid, 0);
    check("rack_finish", finish, 0);
    check("rack_issued", cmds_issued, 0);
    check("rack_cmd", cmd, 0);
    tick();
    reset = 1'b0;
    tick();
    model_en = 1'b1; p0 = n_pulses;
    do_start(6'd4);
    wait_finish(100, "rerun_finish", fin_cyc);
    repeat (4) tick();
    check("rerun_pulses", n_pulses - p0, 3);
    check("rerun_issued", cmds_issued, 3);

    // Watchdog: busy stuck high in EXEC for exactly TIMEOUT=16 cycles
    model_en = 1'b0; man_busy = 1'b0;
    do_start(6'd4);
    tick();
    man_busy = 1'b1;
    repeat (17) tick();
    check("wd_edge18_timeout", timeout, 0);
    tick();
    check("wd_edge19_timeout", timeout, 0);
    tick();
    check("wd_timeout", timeout, 1);
    check("wd_finish", finish, 0);
    check("wd_issued", cmds_issued, 1);
    man_busy = 1'b0;
    tick();
    model_en = 1'b1; p0 = n_pulses;
    do_start(6'd4);
    check("wd_restart_clear", timeout, 0);
    wait_finish(100, "wd_restart_finish", fin_cyc);
    repeat (4) tick();
    check("wd_restart_pulses", n_pulses - p0, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
